// File: rtl/interrupt_sequencer_pkg.sv
// Shared definitions for the interrupt sequencer and the control unit.
//   - irq_state_t   : sequencer state encoding
//   - irq_strobes_t : stack/PC/memory strobe bundle driven toward the CU datapath
//   - VEC_BASE_DEFAULT, ID_W : vector base and IRQ id width
//   - vec_addr()    : 8-bit wrapping vector address computation
package interrupt_sequencer_pkg;

  localparam logic [7:0] VEC_BASE_DEFAULT = 8'hF0;
  localparam int         ID_W             = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_BND,
    ST_DEC_SP,
    ST_PUSH,
    ST_VECTOR,
    ST_ACTIVE,
    ST_POP,
    ST_INC_SP
  } irq_state_t;

  typedef struct packed {
    logic cu_hold;
    logic sp_dec;
    logic sp_inc;
    logic mem_req;
    logic mem_we;
    logic pc_load_vec;
    logic pc_load_mem;
  } irq_strobes_t;

  // Vector address wraps modulo 256.
  function automatic logic [7:0] vec_addr(input logic [7:0] base,
                                          input logic [ID_W-1:0] id);
    return base + {{(8-ID_W){1'b0}}, id};
  endfunction

endpackage

// File: rtl/interrupt_sequencer_prio_enc.sv
// irq_prio_enc: combinational lowest-index priority encoder.
// Ports:
//   i_req   [NUM_IRQ] request vector
//   o_id    [ID_W]    index of the lowest set bit (0 when none set)
//   o_valid           any request set
module irq_prio_enc
  import interrupt_sequencer_pkg::*;
#(
  parameter int NUM_IRQ = 4
) (
  input  logic [NUM_IRQ-1:0] i_req,
  output logic [ID_W-1:0]    o_id,
  output logic               o_valid
);

  // Scan from the top down so the lowest set index wins.
  always_comb begin
    o_id    = '0;
    o_valid = 1'b0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_id    = ID_W'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: single-level interrupt controller for the 8-bit
// multi-cycle CPU. Samples level IRQs, stalls the CU at an instruction
// boundary, pushes the return PC, vectors to the ISR and restores the PC
// on RETI. Memory accesses use a req/gnt handshake with the arbiter.
//
// Optional feature macro: IRQ_MASK_EN (adds a writable NUM_IRQ-bit mask
// register; without it the mask is all-ones and mask_we/mask_wdata are unused).
//
// Ports:
//   clk, rst (async, active-low)
//   irq[NUM_IRQ], ie, boundary, reti, mem_gnt, mask_we, mask_wdata[NUM_IRQ]
//   cu_hold, sp_dec, sp_inc, mem_req, mem_we, pc_load_vec, pc_load_mem,
//   pc_vector[8], irq_ack[NUM_IRQ], in_isr
module interrupt_sequencer
  import interrupt_sequencer_pkg::*;
#(
  parameter int         NUM_IRQ  = 4,
  parameter logic [7:0] VEC_BASE = VEC_BASE_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               ie,
  input  logic               boundary,
  input  logic               reti,
  input  logic               mem_gnt,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  output logic               cu_hold,
  output logic               sp_dec,
  output logic               sp_inc,
  output logic               mem_req,
  output logic               mem_we,
  output logic               pc_load_vec,
  output logic               pc_load_mem,
  output logic [7:0]         pc_vector,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic               in_isr
);

  irq_state_t         r_state;
  logic [ID_W-1:0]    r_id;
  logic               r_in_isr;
  logic [NUM_IRQ-1:0] w_mask;
  logic [NUM_IRQ-1:0] w_pending;
  logic [ID_W-1:0]    w_id;
  logic               w_pend_valid;
  irq_strobes_t       w_strb;

`ifdef IRQ_MASK_EN
  logic [NUM_IRQ-1:0] r_mask;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mask <= '1;
    end else if (mask_we) begin
      r_mask <= mask_wdata;
    end
  end

  assign w_mask = r_mask;
`else
  logic w_unused_mask;

  assign w_unused_mask = ^{mask_we, mask_wdata};
  assign w_mask        = '1;
`endif

  // No nesting: nothing is pending while an ISR runs.
  assign w_pending = (ie && !r_in_isr) ? (irq & w_mask) : '0;

  irq_prio_enc #(
    .NUM_IRQ (NUM_IRQ)
  ) u_prio_enc (
    .i_req   (w_pending),
    .o_id    (w_id),
    .o_valid (w_pend_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_id     <= '0;
      r_in_isr <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pend_valid) r_state <= ST_WAIT_BND;
        end
        ST_WAIT_BND: begin
          if (!w_pend_valid) begin
            r_state <= ST_IDLE;
          end else if (boundary) begin
            r_id    <= w_id;
            r_state <= ST_DEC_SP;
          end
        end
        ST_DEC_SP: r_state <= ST_PUSH;
        ST_PUSH: begin
          if (mem_gnt) r_state <= ST_VECTOR;
        end
        ST_VECTOR: begin
          r_in_isr <= 1'b1;
          r_state  <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (reti) r_state <= ST_POP;
        end
        ST_POP: begin
          if (mem_gnt) r_state <= ST_INC_SP;
        end
        ST_INC_SP: begin
          r_in_isr <= 1'b0;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Strobes decode from the state register so an async reset clears them
  // in the same cycle. The WAIT_BND hold is combinational on boundary so the
  // CU cannot leave fetch1 on the capture edge.
  always_comb begin
    w_strb = '0;
    case (r_state)
      ST_WAIT_BND: w_strb.cu_hold = boundary && w_pend_valid;
      ST_DEC_SP: begin
        w_strb.cu_hold = 1'b1;
        w_strb.sp_dec  = 1'b1;
      end
      ST_PUSH: begin
        w_strb.cu_hold = 1'b1;
        w_strb.mem_req = 1'b1;
        w_strb.mem_we  = 1'b1;
      end
      ST_VECTOR: begin
        w_strb.cu_hold     = 1'b1;
        w_strb.pc_load_vec = 1'b1;
      end
      ST_POP: begin
        w_strb.cu_hold     = 1'b1;
        w_strb.mem_req     = 1'b1;
        w_strb.pc_load_mem = mem_gnt;
      end
      ST_INC_SP: begin
        w_strb.cu_hold = 1'b1;
        w_strb.sp_inc  = 1'b1;
      end
      default: w_strb = '0;
    endcase
  end

  assign cu_hold     = w_strb.cu_hold;
  assign sp_dec      = w_strb.sp_dec;
  assign sp_inc      = w_strb.sp_inc;
  assign mem_req     = w_strb.mem_req;
  assign mem_we      = w_strb.mem_we;
  assign pc_load_vec = w_strb.pc_load_vec;
  assign pc_load_mem = w_strb.pc_load_mem;
  assign pc_vector   = vec_addr(VEC_BASE, r_id);
  assign irq_ack     = (r_state == ST_VECTOR) ? (NUM_IRQ'(1) << r_id) : '0;
  assign in_isr      = r_in_isr;

endmodule

// File: tb/tb_interrupt_sequencer.sv
module tb_interrupt_sequencer;

  logic       clk;
  logic       rst;
  logic [3:0] irq;
  logic       ie;
  logic       boundary;
  logic       reti;
  logic       mem_gnt;
  logic       mask_we;
  logic [3:0] mask_wdata;
  logic       cu_hold;
  logic       sp_dec;
  logic       sp_inc;
  logic       mem_req;
  logic       mem_we;
  logic       pc_load_vec;
  logic       pc_load_mem;
  logic [7:0] pc_vector;
  logic [3:0] irq_ack;
  logic       in_isr;

  int n_chk;
  int n_fail;

  interrupt_sequencer #(
    .NUM_IRQ  (4),
    .VEC_BASE (8'hF0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .irq         (irq),
    .ie          (ie),
    .boundary    (boundary),
    .reti        (reti),
    .mem_gnt     (mem_gnt),
    .mask_we     (mask_we),
    .mask_wdata  (mask_wdata),
    .cu_hold     (cu_hold),
    .sp_dec      (sp_dec),
    .sp_inc      (sp_inc),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .pc_load_vec (pc_load_vec),
    .pc_load_mem (pc_load_mem),
    .pc_vector   (pc_vector),
    .irq_ack     (irq_ack),
    .in_isr      (in_isr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered in a cycle where the DUT is in WAIT_BND with a pending irq.
  task automatic enter(input logic [7:0] vec, input logic [3:0] ack,
                       input int stall, input logic [3:0] irq_after);
    boundary = 1'b1; mem_gnt = 1'b0; #1;
    chk("hold_at_boundary", cu_hold, 1);
    chk("no_dec_yet", sp_dec, 0);
    tick(); boundary = 1'b0; #1;
    chk("sp_dec", sp_dec, 1);
    chk("hold_dec", cu_hold, 1);
    chk("no_req_dec", mem_req, 0);
    for (int k = 0; k < stall; k++) begin
      tick(); mem_gnt = 1'b0; #1;
      chk("stall_req", mem_req, 1);
      chk("stall_we", mem_we, 1);
      chk("stall_hold", cu_hold, 1);
      chk("stall_no_vec", pc_load_vec, 0);
    end
    tick(); mem_gnt = 1'b1; #1;
    chk("push_req", mem_req, 1);
    chk("push_we", mem_we, 1);
    chk("push_dec_single", sp_dec, 0);
    tick(); mem_gnt = 1'b0; irq = irq_after; #1;
    chk("pc_load_vec", pc_load_vec, 1);
    chk("irq_ack", irq_ack, ack);
    chk("pc_vector", pc_vector, vec);
    chk("vec_no_req", mem_req, 0);
    tick(); #1;
    chk("active_hold", cu_hold, 0);
    chk("active_in_isr", in_isr, 1);
    chk("active_ack_single", irq_ack, 0);
  endtask

  // Entered in a cycle where the DUT is in ACTIVE.
  task automatic ret();
    reti = 1'b1; #1;
    tick(); reti = 1'b0; mem_gnt = 1'b1; #1;
    chk("pop_req", mem_req, 1);
    chk("pop_we", mem_we, 0);
    chk("pc_load_mem", pc_load_mem, 1);
    chk("pop_hold", cu_hold, 1);
    tick(); mem_gnt = 1'b0; #1;
    chk("sp_inc", sp_inc, 1);
    chk("inc_no_mem", pc_load_mem, 0);
    tick(); #1;
    chk("idle_in_isr", in_isr, 0);
    chk("idle_hold", cu_hold, 0);
    chk("idle_inc_single", sp_inc, 0);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b0; irq = '0; ie = 1'b0; boundary = 1'b0; reti = 1'b0;
    mem_gnt = 1'b0; mask_we = 1'b0; mask_wdata = '0;
    #12;
    chk("rst_hold", cu_hold, 0);
    chk("rst_pc_vector", pc_vector, 8'hF0);
    chk("rst_in_isr", in_isr, 0);
    chk("rst_strobes", {sp_dec, sp_inc, mem_req, mem_we, pc_load_vec, pc_load_mem}, 0);
    chk("rst_ack", irq_ack, 0);
    rst = 1'b1;
    tick();

    // Single irq, immediate grant.
    ie = 1'b1; irq = 4'b0100; #1;
    tick(); #1;
    chk("wait_bnd_no_hold", cu_hold, 0);
    enter(8'hF2, 4'b0100, 0, 4'b0000);
    ret();

    // Two irqs: lowest wins, reti while irq[3] still high, then irq[3].
    irq = 4'b1010; #1;
    tick(); #1;
    enter(8'hF1, 4'b0010, 0, 4'b1000);
    reti = 1'b1; #1;
    chk("reti_irq_active_no_hold", cu_hold, 0);
    reti = 1'b0;
    ret();
    tick(); #1;
    enter(8'hF3, 4'b1000, 0, 4'b0000);
    ret();

    // Grant withheld 3 cycles in PUSH.
    irq = 4'b0001; #1;
    tick(); #1;
    enter(8'hF0, 4'b0001, 3, 4'b0000);
    ret();

    // Stray reti outside ACTIVE is ignored.
    reti = 1'b1; tick(); reti = 1'b0; #1;
    chk("stray_reti_no_req", mem_req, 0);

    // Pulse dropped before boundary: no hold.
    irq = 4'b0001; tick();
    irq = 4'b0000; tick();
    boundary = 1'b1; #1;
    chk("drop_no_hold", cu_hold, 0);
    tick(); boundary = 1'b0; #1;
    chk("drop_no_dec", sp_dec, 0);
    chk("drop_no_hold2", cu_hold, 0);

    // ie=0 blocks everything.
    ie = 1'b0; irq = 4'b1111; boundary = 1'b1;
    tick(); tick(); #1;
    chk("ie0_no_hold", cu_hold, 0);
    tick(); #1;
    chk("ie0_no_dec", sp_dec, 0);
    irq = '0; boundary = 1'b0; ie = 1'b1;
    tick();

`ifdef IRQ_MASK_EN
    mask_we = 1'b1; mask_wdata = 4'b1110;
    tick(); mask_we = 1'b0;
    irq = 4'b0001; boundary = 1'b1;
    tick(); tick(); #1;
    chk("masked_no_hold", cu_hold, 0);
    tick(); #1;
    chk("masked_no_dec", sp_dec, 0);
    irq = '0; boundary = 1'b0;
    mask_we = 1'b1; mask_wdata = 4'b1111;
    tick(); mask_we = 1'b0;
`endif

    // Async reset while stalled in PUSH.
    irq = 4'b0010; #1;
    tick(); #1;
    boundary = 1'b1; tick(); boundary = 1'b0;
    tick(); #1;
    chk("pre_rst_push_req", mem_req, 1);
    rst = 1'b0; #1;
    chk("rst_mid_req", mem_req, 0);
    chk("rst_mid_we", mem_we, 0);
    chk("rst_mid_hold", cu_hold, 0);
    chk("rst_mid_in_isr", in_isr, 0);
    irq = '0;
    tick(); rst = 1'b1;
    tick(); tick(); #1;
    chk("post_rst_req", mem_req, 0);
    chk("post_rst_hold", cu_hold, 0);
    chk("post_rst_vec", pc_vector, 8'hF0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
